iter_ctrl_fsm: RTL

//  Parametrised start/ready sequencing controller for iterative datapaths. Runs a configurable

---
 rtl/iter_ctrl_fsm_pkg.sv | 18 +
 rtl/iter_ctrl_fsm_iter_counter.sv | 39 +++
 rtl/iter_ctrl_fsm.sv | 125 ++++++++++++
 3 files changed

// File: rtl/iter_ctrl_fsm_pkg.sv
// Shared definitions for iterative-datapath sequencing controllers:
// state encoding and counter sizing helper.
package iter_ctrl_fsm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Width of a counter that must hold indices 0..n-1 (at least one bit).
  function automatic int cnt_w_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/iter_ctrl_fsm_iter_counter.sv
// Up-counter with sync clear, loadable terminal value and terminal-count flag.
// The caller clears it on terminal count so it never runs past the loaded maximum.
module iter_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_max,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] r_max;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  // Terminal value is configuration, only meaningful after a load.
  always_ff @(posedge clk) begin
    if (i_load) begin
      r_max <= i_max;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == r_max);

endmodule

// File: rtl/iter_ctrl_fsm.sv
// Start/ready sequencer: P passes of N compute iterations, each pass followed by a
// fixed drain, driving datapath register clear/write enables.
module iter_ctrl_fsm
  import iter_ctrl_fsm_pkg::*;
#(
  parameter int CNT_W        = 4,
  parameter int PASS_W       = 2,
  parameter int DRAIN_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  n_iter,
  input  logic [PASS_W-1:0] n_pass,
  output logic              regRst,
  output logic              regWrite,
  output logic              ready,
  output logic              done,
  output logic              busy,
  output logic [CNT_W-1:0]  iter,
  output logic [PASS_W-1:0] pass_idx
);

  localparam int              DW        = cnt_w_for(DRAIN_CYCLES);
  localparam logic [DW-1:0]   DRAIN_MAX = DW'(DRAIN_CYCLES - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PASS_W-1:0]   r_pass;
  logic [PASS_W-1:0]   r_pass_max;
  logic                r_regRst;
  logic                r_regWrite;
  logic                r_ready;
  logic                r_done;
  logic                r_busy;

  logic                w_accept;
  logic [CNT_W-1:0]    w_iter_cnt;
  logic                w_iter_tc;
  logic [DW-1:0]       w_drain_cnt;
  logic                w_drain_tc;
  logic                w_drain_last;

  assign w_accept     = (r_state == ST_IDLE) && start && !abort;
  assign w_drain_last = (w_drain_cnt == DRAIN_MAX);

  // Counting n-1 in CNT_W bits makes n_iter=0 wrap to the full 2**CNT_W range.
  iter_counter #(.W(CNT_W)) u_iter_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  ((r_state != ST_RUN) || w_iter_tc),
    .i_load (w_accept),
    .i_max  (n_iter - CNT_W'(1)),
    .i_en   (r_state == ST_RUN),
    .o_cnt  (w_iter_cnt),
    .o_tc   (w_iter_tc)
  );

  iter_counter #(.W(DW)) u_drain_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  ((r_state != ST_DRAIN) || w_drain_tc),
    .i_load (w_accept),
    .i_max  (DRAIN_MAX),
    .i_en   (r_state == ST_DRAIN),
    .o_cnt  (w_drain_cnt),
    .o_tc   (w_drain_tc)
  );

  always_comb begin
    w_state_nxt = r_state;
    if ((r_state != ST_IDLE) && abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE:  if (w_accept) w_state_nxt = ST_INIT;
        ST_INIT:  w_state_nxt = ST_RUN;
        ST_RUN:   if (w_iter_tc) w_state_nxt = ST_DRAIN;
        ST_DRAIN: if (w_drain_last)
                    w_state_nxt = (r_pass == r_pass_max) ? ST_DONE : ST_RUN;
        ST_DONE:  if (!start) w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they align with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_pass     <= '0;
      r_regRst   <= 1'b1;
      r_regWrite <= 1'b0;
      r_ready    <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_pass_max <= n_pass - PASS_W'(1);
      end
      if ((r_state == ST_DRAIN) && (w_state_nxt == ST_RUN)) begin
        r_pass <= r_pass + PASS_W'(1);
      end else if (!((w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN))) begin
        r_pass <= '0;
      end
      r_regRst   <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_INIT);
      r_regWrite <= (w_state_nxt == ST_RUN)  || (w_state_nxt == ST_DRAIN);
      r_busy     <= (w_state_nxt == ST_INIT) || (w_state_nxt == ST_RUN) ||
                    (w_state_nxt == ST_DRAIN);
      r_ready    <= (w_state_nxt == ST_DONE);
      r_done     <= (w_state_nxt == ST_DONE) && (r_state != ST_DONE);
    end
  end

  assign regRst   = r_regRst;
  assign regWrite = r_regWrite;
  assign ready    = r_ready;
  assign done     = r_done;
  assign busy     = r_busy;
  assign iter     = (r_state == ST_RUN) ? w_iter_cnt : '0;
  assign pass_idx = r_pass;

endmodule
